// File: rtl/gmii_arb_pkg.sv
// Shared state encoding and parameter defaults for the two-port GMII
// transmit arbiter.
package gmii_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_SEND,
    ST_IPG
  } arb_state_e;

  localparam int IPG_CYCLES_DEF    = 12;
  localparam int MAX_FRAME_DEF     = 1530;
  localparam int START_TIMEOUT_DEF = 16;

  // One counter serves timeout, byte count and IPG, so it is sized for the largest.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side
// that did not hold the last grant.
module rr_arbiter2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic vld_o,
  output logic idx_o
);

  assign vld_o = req0_i | req1_i;
  assign idx_o = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Grants one of two GMII sources access to a shared PCS transmitter, forwards
// the owner's bus one cycle late, truncates oversize frames and enforces IPG.
module gmii_tx_arbiter
  import gmii_arb_pkg::*;
#(
  parameter int IPG_CYCLES    = IPG_CYCLES_DEF,
  parameter int MAX_FRAME     = MAX_FRAME_DEF,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] TXD0,
  input  logic [7:0] TXD1,
  input  logic       TX_EN0,
  input  logic       TX_EN1,
  input  logic       TX_ER0,
  input  logic       TX_ER1,
  input  logic       transmitting,
  output logic       grant0,
  output logic       grant1,
  output logic [7:0] TXD,
  output logic       TX_EN,
  output logic       TX_ER,
  output logic       owner,
  output logic       oversize
);

  localparam int CW = $clog2(max3(MAX_FRAME, IPG_CYCLES, START_TIMEOUT) + 1);
  localparam logic [CW-1:0] MAXF     = CW'(MAX_FRAME);
  localparam logic [CW-1:0] IPG_LAST = CW'(IPG_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(START_TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          g0_q, g0_d, g1_q, g1_d, owner_q, owner_d;
  logic [7:0]    txd_q, txd_d;
  logic          txen_q, txen_d, txer_q, txer_d, ovs_q, ovs_d;
  logic          arb_vld, arb_idx;
  logic          own_en, own_er;
  logic [7:0]    own_d;

  rr_arbiter2 u_rr (
    .req0_i (req0),
    .req1_i (req1),
    .last_i (owner_q),
    .vld_o  (arb_vld),
    .idx_o  (arb_idx)
  );

  // Only the owner's lane is ever selected onto the output path.
  assign own_en = owner_q ? TX_EN1 : TX_EN0;
  assign own_er = owner_q ? TX_ER1 : TX_ER0;
  assign own_d  = owner_q ? TXD1   : TXD0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g0_d    = g0_q;
    g1_d    = g1_q;
    owner_d = owner_q;
    txd_d   = 8'h00;
    txen_d  = 1'b0;
    txer_d  = 1'b0;
    ovs_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        g0_d = 1'b0;
        g1_d = 1'b0;
        if (arb_vld && !transmitting) begin
          g0_d    = ~arb_idx;
          g1_d    = arb_idx;
          owner_d = arb_idx;
          cnt_d   = '0;
          state_d = ST_WAIT_SOF;
        end
      end
      ST_WAIT_SOF: begin
        if (own_en) begin
          txd_d   = own_d;
          txen_d  = 1'b1;
          txer_d  = own_er;
          cnt_d   = CW'(1);
          state_d = ST_SEND;
        end else if (cnt_q == TMO_LAST) begin
          g0_d    = 1'b0;
          g1_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SEND: begin
        if (!own_en) begin
          g0_d    = 1'b0;
          g1_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_IPG;
        end else if (cnt_q == MAXF) begin
          // Truncate: one errored byte marks the frame bad, then the bus goes idle.
          txd_d   = own_d;
          txen_d  = 1'b1;
          txer_d  = 1'b1;
          ovs_d   = 1'b1;
          g0_d    = 1'b0;
          g1_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_IPG;
        end else begin
          txd_d  = own_d;
          txen_d = 1'b1;
          txer_d = own_er;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      ST_IPG: begin
        if (cnt_q == IPG_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge GTX_CLK) begin
    if (!mr_main_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      g0_q    <= 1'b0;
      g1_q    <= 1'b0;
      owner_q <= 1'b1;
      txd_q   <= 8'h00;
      txen_q  <= 1'b0;
      txer_q  <= 1'b0;
      ovs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
      owner_q <= owner_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      txer_q  <= txer_d;
      ovs_q   <= ovs_d;
    end
  end

  assign grant0   = g0_q;
  assign grant1   = g1_q;
  assign owner    = owner_q;
  assign TXD      = txd_q;
  assign TX_EN    = txen_q;
  assign TX_ER    = txer_q;
  assign oversize = ovs_q;

endmodule

// File: doc/gmii_tx_arbiter.md
GMII_TX_ARBITER -- requirements
Module: gmii_tx_arbiter

Interface
REQ-001 Parameter IPG_CYCLES, default 12, SHALL set the minimum idle cycles on TX_EN between granted frames.
REQ-002 Parameter MAX_FRAME, default 1530, SHALL set the maximum TX_EN-high bytes per frame.
REQ-003 Parameter START_TIMEOUT, default 16, SHALL set the cycles a granted requester has to raise its enable.
REQ-004 GTX_CLK  in  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 mr_main_reset  in  1  SHALL be a synchronous, active-low reset.
REQ-006 req0, req1  in  1 each  SHALL be the requester frame-pending requests.
REQ-007 TXD0, TXD1  in  8 each  SHALL be the requester GMII data bytes.
REQ-008 TX_EN0, TX_EN1 / TX_ER0, TX_ER1  in  1 each  SHALL be the requester GMII enable and error signals.
REQ-009 transmitting  in  1  SHALL be the PCS TRANSMIT busy flag.
REQ-010 grant0, grant1  out  1 each  SHALL be one-hot-or-zero ownership grants.
REQ-011 TXD  out  8, TX_EN  out  1, TX_ER  out  1  SHALL be the registered GMII bus to the PCS transmitter.
REQ-012 owner  out  1  SHALL be the index of the current or last grant holder.
REQ-013 oversize  out  1  SHALL be a one-cycle pulse on frame truncation.

Function
REQ-014 FSM states: IDLE, WAIT_SOF, SEND, IPG.
REQ-015 IDLE: no grant; if (req0|req1) and transmitting==0, next edge SHALL assert the chosen grant, update owner, enter WAIT_SOF.
REQ-016 Selection: single requester wins; on both, the one not equal to owner wins (round-robin).
REQ-017 WAIT_SOF: grant held; owner TX_ENx=1 SHALL enter SEND and set byte count to 1; START_TIMEOUT cycles without it SHALL drop the grant and return to IDLE (no IPG).
REQ-018 SEND: TXD/TX_EN/TX_ER SHALL equal owner's TXDx/TX_ENx/TX_ERx delayed exactly one cycle; byte count increments each TX_ENx-high cycle.
REQ-019 SEND: owner TX_ENx falling SHALL drop the grant on the same edge that registers TX_EN=0 and enter IPG.
REQ-020 Byte count reaching MAX_FRAME with TX_ENx still high: next output cycle SHALL be TX_EN=1, TX_ER=1, oversize=1, then TX_EN=0; grant dropped; enter IPG; remaining owner bytes ignored.
REQ-021 IPG: outputs idle for exactly IPG_CYCLES cycles, then IDLE; requests during IPG SHALL NOT be granted.
REQ-022 Outside SEND outputs SHALL be TXD=8'h00, TX_EN=0, TX_ER=0; non-owner inputs SHALL never reach outputs.
REQ-023 Requester dropping reqx while granted SHALL NOT affect the grant; only TX_ENx or timeout ends it.
REQ-024 Counters SHALL be sized for MAX_FRAME and not wrap.

Reset
REQ-025 mr_main_reset=0 at an edge SHALL force IDLE, grants 0, TXD=8'h00, TX_EN=0, TX_ER=0, oversize=0, counters 0, owner=1 (req0 wins first tie), including mid-frame.
REQ-026 First grant possible on the second edge after reset release.

Structure
REQ-027 Package gmii_arb_pkg SHALL hold the state enumeration and parameter defaults.
REQ-028 Sub-module rr_arbiter2 SHALL implement the two-way round-robin selection of REQ-016.

Verification
REQ-029 req0 only, 10-byte frame 01,03,9A,B5,42,02,42,9A,B5,01 -> same bytes on TXD one cycle late, TX_EN high 10 cycles, then >=12 idle cycles.
REQ-030 req0 and req1 together after reset -> grant0 first; after IPG grant1; subsequent ties alternate.
REQ-031 Granted requester never raises TX_EN -> grant drops after 16 cycles, no TX_EN output, next request granted without IPG.
REQ-032 2000-byte frame -> 1530 bytes forwarded, cycle 1531 shows TX_EN=1 TX_ER=1 oversize=1, then TX_EN=0.
REQ-033 Reset asserted at byte 5 of a frame -> next edge all outputs 0, grants 0, owner=1.
REQ-034 transmitting=1 with req1 pending -> no grant until transmitting=0, grant1 one edge later.
